// File: rtl/uart_pkg.sv
// Shared encodings and frame-size helper for the queued UART transmitter.
package uart_pkg;

    typedef enum logic [3:0] {
        ESTADO_INICIAL   = 4'd0,
        ESTADO_PREPARA   = 4'd1,
        ESTADO_TRANSMITE = 4'd2,
        ESTADO_FINAL     = 4'd3
    } estado_t;

    localparam int PAR_NENHUMA = 0;
    localparam int PAR_PAR     = 1;
    localparam int PAR_IMPAR   = 2;

    function automatic int tamanho_quadro(input int n_dados, input int paridade, input int n_stop);
        return 1 + n_dados + ((paridade != PAR_NENHUMA) ? 1 : 0) + n_stop;
    endfunction

endpackage

// File: rtl/fifo_tx.sv
// Small synchronous FIFO with registered full/empty flags and a combinational head.
module fifo_tx #(
    parameter int LARGURA      = 8,
    parameter int PROFUNDIDADE = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [LARGURA-1:0] dados,
    output logic [LARGURA-1:0] cabeca,
    output logic               cheio,
    output logic               vazio
);

    localparam int PW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
    localparam int CW = $clog2(PROFUNDIDADE + 1);

    logic [LARGURA-1:0] mem_q [PROFUNDIDADE];
    logic [PW-1:0]      wr_q;
    logic [PW-1:0]      rd_q;
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_d;
    logic               cheio_q;
    logic               vazio_q;
    logic               push_ok;
    logic               pop_ok;

    // A push into a full FIFO is still taken when the head leaves in the same cycle.
    assign pop_ok  = pop && !vazio_q;
    assign push_ok = push && (!cheio_q || pop_ok);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            cheio_q <= 1'b0;
            vazio_q <= 1'b1;
        end else begin
            if (push_ok) wr_q <= wr_q + PW'(1);
            if (pop_ok)  rd_q <= rd_q + PW'(1);
            count_q <= count_d;
            cheio_q <= (count_d == CW'(PROFUNDIDADE));
            vazio_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_q] <= dados;
    end

    assign cabeca = mem_q[rd_q];
    assign cheio  = cheio_q;
    assign vazio  = vazio_q;

endmodule

// File: rtl/uart_tx_fila.sv
// Queued asynchronous serial transmitter: edge-detected push into a FIFO,
// then one frame per byte with configurable data width, parity and stop bits.
module uart_tx_fila
    import uart_pkg::*;
#(
    parameter int N_DADOS      = 8,
    parameter int PARIDADE     = 0,
    parameter int N_STOP       = 1,
    parameter int DIVISOR      = 434,
    parameter int PROFUNDIDADE = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic [7:0] dados,
    output logic       saida_serial,
    output logic       pronto,
    output logic       cheio,
    output logic       vazio,
    output logic       db_tick,
    output logic       db_partida,
    output logic       db_saida_serial,
    output logic [3:0] db_estado
);

    localparam int F  = tamanho_quadro(N_DADOS, PARIDADE, N_STOP);
    localparam int BW = $clog2(DIVISOR);
    localparam int CW = $clog2(F + 1);
    localparam logic [BW-1:0] BAUD_MAX = BW'(DIVISOR - 1);
    localparam logic [CW-1:0] BIT_MAX  = CW'(F - 1);

    estado_t              estado_q;
    logic                 db_partida_q;
    logic                 saida_q;
    logic                 pronto_q;
    logic                 tick_q;
    logic [BW-1:0]        baud_q;
    logic [CW-1:0]        bit_q;
    logic [F-1:0]         quadro_q;
    logic [F-1:0]         quadro_d;
    logic [N_DADOS-1:0]   cabeca;
    logic                 paridade_bit;
    logic                 push;
    logic                 pop;
    logic                 dados_unused;

    assign dados_unused = ^dados;
    assign push = partida && !db_partida_q;
    assign pop  = (estado_q == ESTADO_PREPARA);

    fifo_tx #(
        .LARGURA      (N_DADOS),
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .dados  (dados[N_DADOS-1:0]),
        .cabeca (cabeca),
        .cheio  (cheio),
        .vazio  (vazio)
    );

    // Whole frame, LSB first: start, data, optional parity, stop ones.
    always_comb begin
        paridade_bit = ^cabeca;
        if (PARIDADE == PAR_IMPAR) paridade_bit = ~paridade_bit;
        quadro_d              = '1;
        quadro_d[0]           = 1'b0;
        quadro_d[N_DADOS:1]   = cabeca;
        if (PARIDADE != PAR_NENHUMA) quadro_d[N_DADOS+1] = paridade_bit;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q     <= ESTADO_INICIAL;
            db_partida_q <= 1'b0;
            saida_q      <= 1'b1;
            pronto_q     <= 1'b0;
            tick_q       <= 1'b0;
            baud_q       <= '0;
            bit_q        <= '0;
            quadro_q     <= '1;
        end else begin
            db_partida_q <= partida;
            pronto_q     <= 1'b0;
            tick_q       <= 1'b0;
            case (estado_q)
                ESTADO_INICIAL: begin
                    saida_q <= 1'b1;
                    if (!vazio) estado_q <= ESTADO_PREPARA;
                end
                ESTADO_PREPARA: begin
                    quadro_q <= quadro_d;
                    saida_q  <= quadro_d[0];
                    baud_q   <= '0;
                    bit_q    <= '0;
                    estado_q <= ESTADO_TRANSMITE;
                end
                ESTADO_TRANSMITE: begin
                    if (baud_q == BAUD_MAX) begin
                        baud_q <= '0;
                        tick_q <= 1'b1;
                        if (bit_q == BIT_MAX) begin
                            saida_q  <= 1'b1;
                            pronto_q <= 1'b1;
                            estado_q <= ESTADO_FINAL;
                        end else begin
                            bit_q    <= bit_q + CW'(1);
                            quadro_q <= {1'b1, quadro_q[F-1:1]};
                            saida_q  <= quadro_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                ESTADO_FINAL: begin
                    saida_q  <= 1'b1;
                    estado_q <= vazio ? ESTADO_INICIAL : ESTADO_PREPARA;
                end
                default: estado_q <= ESTADO_INICIAL;
            endcase
        end
    end

    assign saida_serial    = saida_q;
    assign db_saida_serial = saida_q;
    assign pronto          = pronto_q;
    assign db_tick         = tick_q;
    assign db_partida      = db_partida_q;
    assign db_estado       = estado_q;

endmodule

// File: tb/tb_uart_tx_fila.sv
// Bench for uart_tx_fila: three configurations (8N1, 8E1, 7O2) at 8 clocks per bit,
// frames compared sample-by-sample against a bit-list model of the frame format.
module tb_uart_tx_fila;

    localparam int DIV = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] partida;
    logic [7:0] dados [3];
    wire  [2:0] line_w, pronto_w, cheio_w, vazio_w, tick_w, dbp_w, dbs_w;
    wire  [3:0] est_w [3];
    int         n_checks = 0;
    int         n_pass   = 0;

    always #5 clk = ~clk;

    uart_tx_fila #(.N_DADOS(8), .PARIDADE(0), .N_STOP(1), .DIVISOR(DIV), .PROFUNDIDADE(4)) u_8n1 (
        .clock(clk), .reset(rst), .partida(partida[0]), .dados(dados[0]),
        .saida_serial(line_w[0]), .pronto(pronto_w[0]), .cheio(cheio_w[0]), .vazio(vazio_w[0]),
        .db_tick(tick_w[0]), .db_partida(dbp_w[0]), .db_saida_serial(dbs_w[0]), .db_estado(est_w[0]));

    uart_tx_fila #(.N_DADOS(8), .PARIDADE(1), .N_STOP(1), .DIVISOR(DIV), .PROFUNDIDADE(4)) u_8e1 (
        .clock(clk), .reset(rst), .partida(partida[1]), .dados(dados[1]),
        .saida_serial(line_w[1]), .pronto(pronto_w[1]), .cheio(cheio_w[1]), .vazio(vazio_w[1]),
        .db_tick(tick_w[1]), .db_partida(dbp_w[1]), .db_saida_serial(dbs_w[1]), .db_estado(est_w[1]));

    uart_tx_fila #(.N_DADOS(7), .PARIDADE(2), .N_STOP(2), .DIVISOR(DIV), .PROFUNDIDADE(4)) u_7o2 (
        .clock(clk), .reset(rst), .partida(partida[2]), .dados(dados[2]),
        .saida_serial(line_w[2]), .pronto(pronto_w[2]), .cheio(cheio_w[2]), .vazio(vazio_w[2]),
        .db_tick(tick_w[2]), .db_partida(dbp_w[2]), .db_saida_serial(dbs_w[2]), .db_estado(est_w[2]));

    function automatic int cfg_nd(input int idx);
        return (idx == 2) ? 7 : 8;
    endfunction

    function automatic int cfg_ns(input int idx);
        return (idx == 2) ? 2 : 1;
    endfunction

    // Frame as a list of bits (start, data LSB first, parity, stops), each stretched to DIV samples.
    function automatic int modelo(input int idx, input logic [7:0] b,
                                  output logic [127:0] wave, output logic par_bit);
        int bits[$];
        int ones;
        ones = 0;
        bits.push_back(0);
        for (int i = 0; i < cfg_nd(idx); i++) begin
            bits.push_back((b >> i) & 1);
            ones += (b >> i) & 1;
        end
        par_bit = 1'b0;
        if (idx != 0) begin
            par_bit = (ones % 2) == 1;
            if (idx == 2) par_bit = !par_bit;
            bits.push_back(int'(par_bit));
        end
        for (int s = 0; s < cfg_ns(idx); s++) bits.push_back(1);
        wave = '0;
        foreach (bits[j])
            for (int t = 0; t < DIV; t++) wave[j*DIV+t] = bits[j][0];
        return bits.size();
    endfunction

    // Waits (bounded) for a start bit, then records nbits*DIV line samples and the cycle after.
    task automatic capture(input int idx, input int nbits, output bit found, output int gap,
                           output logic [127:0] wf, output int pr_in, output int ticks,
                           output logic pr_end, output logic line_end);
        found = 0; gap = 0; wf = '0; pr_in = 0; ticks = 0; pr_end = 1'b0; line_end = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (line_w[idx] === 1'b0) found = 1;
            else gap++;
        end
        if (!found) return;
        for (int i = 0; i < nbits*DIV; i++) begin
            if (i > 0) @(negedge clk);
            wf[i] = line_w[idx];
            pr_in += int'(pronto_w[idx]);
            ticks += int'(tick_w[idx]);
        end
        @(negedge clk);
        pr_end   = pronto_w[idx];
        line_end = line_w[idx];
        ticks   += int'(tick_w[idx]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        partida = '0;
        for (int i = 0; i < 3; i++) dados[i] = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++; if (line_w !== 3'b111) $display("FAIL reset_line: got %b expected 111", line_w); else n_pass++;
        n_checks++; if (pronto_w !== 3'b000) $display("FAIL reset_pronto: got %b expected 000", pronto_w); else n_pass++;
        n_checks++; if (cheio_w !== 3'b000) $display("FAIL reset_cheio: got %b expected 000", cheio_w); else n_pass++;
        n_checks++; if (vazio_w !== 3'b111) $display("FAIL reset_vazio: got %b expected 111", vazio_w); else n_pass++;
        n_checks++; if (tick_w !== 3'b000 || dbp_w !== 3'b000) $display("FAIL reset_dbg: tick %b partida %b expected 000", tick_w, dbp_w); else n_pass++;
        n_checks++; if (est_w[0] !== 4'd0 || est_w[1] !== 4'd0 || est_w[2] !== 4'd0)
            $display("FAIL reset_estado: got %0d %0d %0d expected 0", est_w[0], est_w[1], est_w[2]); else n_pass++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        $display("reset: line=%b vazio=%b estado=%0d", line_w, vazio_w, est_w[0]);
    endtask

    task automatic test_single();
        logic [127:0] exp, wf;
        logic pb, pr_end, line_end;
        int nb, gap, pr_in, ticks, lows;
        bit found;
        nb = modelo(0, 8'h35, exp, pb);
        @(negedge clk);
        dados[0] = 8'h35;
        partida[0] = 1'b1;
        fork
            begin
                repeat (5) @(negedge clk);
                n_checks++; if (dbp_w[0] !== 1'b1) $display("FAIL single_db_partida: got %b expected 1", dbp_w[0]); else n_pass++;
                repeat (15) @(negedge clk);
                n_checks++; if (est_w[0] !== 4'd2) $display("FAIL single_estado_tx: got %0d expected 2", est_w[0]); else n_pass++;
                n_checks++; if (dbs_w[0] !== exp[17]) $display("FAIL single_db_saida: got %b expected %b", dbs_w[0], exp[17]); else n_pass++;
                repeat (5) @(negedge clk);
                partida[0] = 1'b0;
            end
            capture(0, nb, found, gap, wf, pr_in, ticks, pr_end, line_end);
        join
        n_checks++;
        if (!found) $display("FAIL single_timeout: no start bit within 40 cycles");
        else if (wf !== exp) $display("FAIL single_wave: got %h expected %h", wf, exp);
        else n_pass++;
        n_checks++; if (gap !== 2) $display("FAIL single_latency: got %0d idle cycles expected 2", gap); else n_pass++;
        n_checks++; if (pr_in !== 0 || pr_end !== 1'b1 || line_end !== 1'b1)
            $display("FAIL single_pronto: in-frame %0d end %b line %b expected 0 1 1", pr_in, pr_end, line_end); else n_pass++;
        n_checks++; if (ticks !== nb) $display("FAIL single_ticks: got %0d expected %0d", ticks, nb); else n_pass++;
        @(negedge clk);
        n_checks++; if (pronto_w[0] !== 1'b0 || dbp_w[0] !== 1'b0)
            $display("FAIL single_after: pronto %b db_partida %b expected 0 0", pronto_w[0], dbp_w[0]); else n_pass++;
        lows = 0;
        repeat (30) begin
            @(negedge clk);
            if (line_w[0] !== 1'b1) lows++;
        end
        n_checks++; if (lows !== 0 || vazio_w[0] !== 1'b1 || est_w[0] !== 4'd0)
            $display("FAIL single_one_push: lows %0d vazio %b estado %0d expected 0 1 0", lows, vazio_w[0], est_w[0]); else n_pass++;
        $display("single 8N1 byte 35: gap=%0d ticks=%0d pronto=%b", gap, ticks, pr_end);
    endtask

    task automatic test_frames();
        int idx_t [8];
        logic [7:0] b_t [8];
        idx_t[0] = 1; b_t[0] = 8'hD5;
        idx_t[1] = 2; b_t[1] = 8'h7E;
        for (int i = 2; i < 8; i++) begin
            idx_t[i] = i % 3;
            b_t[i]   = 8'($urandom_range(0, 255));
        end
        for (int n = 0; n < 8; n++) begin
            logic [127:0] exp, wf;
            logic pb, pr_end, line_end;
            int nb, gap, pr_in, ticks, idx;
            bit found;
            idx = idx_t[n];
            nb = modelo(idx, b_t[n], exp, pb);
            @(negedge clk);
            dados[idx] = b_t[n];
            partida[idx] = 1'b1;
            fork
                begin @(negedge clk); partida[idx] = 1'b0; end
                capture(idx, nb, found, gap, wf, pr_in, ticks, pr_end, line_end);
            join
            n_checks++;
            if (!found) $display("FAIL frame%0d_timeout: no start bit on dut %0d", n, idx);
            else if (wf !== exp) $display("FAIL frame%0d_wave: got %h expected %h", n, wf, exp);
            else n_pass++;
            if (idx != 0) begin
                n_checks++; if (wf[(cfg_nd(idx)+1)*DIV + DIV/2] !== pb)
                    $display("FAIL frame%0d_parity: got %b expected %b", n, wf[(cfg_nd(idx)+1)*DIV + DIV/2], pb); else n_pass++;
            end
            n_checks++; if (gap !== 2) $display("FAIL frame%0d_latency: got %0d expected 2", n, gap); else n_pass++;
            n_checks++; if (pr_in !== 0 || pr_end !== 1'b1 || line_end !== 1'b1 || ticks !== nb)
                $display("FAIL frame%0d_end: pronto in %0d end %b line %b ticks %0d expected 0 1 1 %0d", n, pr_in, pr_end, line_end, ticks, nb); else n_pass++;
            $display("frame dut=%0d byte=%h bits=%0d parity=%b pronto=%b", idx, b_t[n], nb, pb, pr_end);
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] tx [6];
        logic [3:0] cheio_seen;
        logic cheio_drop, vazio_drop, cheio_pp_before, cheio_pp_after;
        logic [3:0] est_fin, est_pp;
        bit pr_found;
        int lows;
        logic [127:0] wf_a [6];
        int gap_a [6], ticks_a [6], pr_in_a [6];
        logic pr_end_a [6], line_end_a [6];
        bit found_a [6];
        tx[0] = 8'($urandom_range(0, 255));
        tx[1] = 8'hB5; tx[2] = 8'hD5; tx[3] = 8'hFE; tx[4] = 8'hFF; tx[5] = 8'h5A;
        cheio_seen = '0; cheio_drop = 0; vazio_drop = 0; cheio_pp_before = 0; cheio_pp_after = 0;
        est_fin = '0; est_pp = '0; pr_found = 0;
        @(negedge clk);
        dados[0] = tx[0];
        partida[0] = 1'b1;
        fork
            begin
                @(negedge clk); partida[0] = 1'b0;
                for (int j = 1; j <= 4; j++) begin
                    @(negedge clk); partida[0] = 1'b1; dados[0] = tx[j];
                    @(negedge clk); partida[0] = 1'b0; cheio_seen[j-1] = cheio_w[0];
                end
                @(negedge clk); partida[0] = 1'b1; dados[0] = 8'h00;
                @(negedge clk); partida[0] = 1'b0; cheio_drop = cheio_w[0]; vazio_drop = vazio_w[0];
            end
            begin
                for (int f = 0; f < 6; f++) begin
                    logic [127:0] e, w;
                    logic pb, pe, le;
                    int nb, g, pi, tk;
                    bit fd;
                    nb = modelo(0, tx[f], e, pb);
                    capture(0, nb, fd, g, w, pi, tk, pe, le);
                    found_a[f] = fd; gap_a[f] = g; wf_a[f] = w; pr_in_a[f] = pi;
                    ticks_a[f] = tk; pr_end_a[f] = pe; line_end_a[f] = le;
                end
            end
            begin
                for (int c = 0; c < 300 && !pr_found; c++) begin
                    @(negedge clk);
                    if (pronto_w[0] === 1'b1) pr_found = 1;
                end
                est_fin = est_w[0];
                @(negedge clk);
                est_pp = est_w[0];
                cheio_pp_before = cheio_w[0];
                partida[0] = 1'b1; dados[0] = tx[5];
                @(negedge clk);
                cheio_pp_after = cheio_w[0];
                partida[0] = 1'b0;
            end
        join
        n_checks++; if (cheio_seen !== 4'b1000) $display("FAIL b2b_cheio_fill: got %b expected 1000", cheio_seen); else n_pass++;
        n_checks++; if (cheio_drop !== 1'b1 || vazio_drop !== 1'b0)
            $display("FAIL b2b_drop_flags: cheio %b vazio %b expected 1 0", cheio_drop, vazio_drop); else n_pass++;
        n_checks++; if (!pr_found || est_fin !== 4'd3) $display("FAIL b2b_final_state: found %0d estado %0d expected 1 3", pr_found, est_fin); else n_pass++;
        n_checks++; if (est_pp !== 4'd1 || cheio_pp_before !== 1'b1 || cheio_pp_after !== 1'b1)
            $display("FAIL b2b_push_on_pop: estado %0d cheio %b/%b expected 1 1/1", est_pp, cheio_pp_before, cheio_pp_after); else n_pass++;
        for (int f = 0; f < 6; f++) begin
            logic [127:0] e;
            logic pb;
            int nb;
            nb = modelo(0, tx[f], e, pb);
            n_checks++;
            if (!found_a[f]) $display("FAIL b2b%0d_timeout: no start bit", f);
            else if (wf_a[f] !== e) $display("FAIL b2b%0d_wave: got %h expected %h", f, wf_a[f], e);
            else n_pass++;
            n_checks++; if (gap_a[f] !== ((f == 0) ? 2 : 1))
                $display("FAIL b2b%0d_gap: got %0d expected %0d", f, gap_a[f], (f == 0) ? 2 : 1); else n_pass++;
            n_checks++; if (pr_in_a[f] !== 0 || pr_end_a[f] !== 1'b1 || line_end_a[f] !== 1'b1 || ticks_a[f] !== nb)
                $display("FAIL b2b%0d_end: pronto in %0d end %b line %b ticks %0d", f, pr_in_a[f], pr_end_a[f], line_end_a[f], ticks_a[f]); else n_pass++;
            $display("b2b frame %0d byte=%h gap=%0d pronto=%b", f, tx[f], gap_a[f], pr_end_a[f]);
        end
        lows = 0;
        repeat (30) begin
            @(negedge clk);
            if (line_w[0] !== 1'b1) lows++;
        end
        n_checks++; if (lows !== 0 || vazio_w[0] !== 1'b1)
            $display("FAIL b2b_tail: lows %0d vazio %b expected 0 1", lows, vazio_w[0]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] x, y, z, w_b;
        logic [127:0] exp, wf;
        logic pb, pr_end, line_end;
        int nb, gap, pr_in, ticks, lows, prs;
        bit found;
        x = 8'($urandom_range(0, 255));
        y = 8'($urandom_range(0, 255));
        z = 8'($urandom_range(0, 255));
        @(negedge clk); partida[0] = 1'b1; dados[0] = x;
        @(negedge clk); partida[0] = 1'b0;
        @(negedge clk); partida[0] = 1'b1; dados[0] = y;
        @(negedge clk); partida[0] = 1'b0;
        @(negedge clk); partida[0] = 1'b1; dados[0] = z;
        @(negedge clk); partida[0] = 1'b0;
        repeat (33) @(negedge clk);
        n_checks++; if (line_w[0] !== x[3] || vazio_w[0] !== 1'b0)
            $display("FAIL rstmid_before: line %b vazio %b expected %b 0", line_w[0], vazio_w[0], x[3]); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (line_w[0] !== 1'b1 || vazio_w[0] !== 1'b1 || est_w[0] !== 4'd0 || pronto_w[0] !== 1'b0)
            $display("FAIL rstmid_async: line %b vazio %b estado %0d pronto %b expected 1 1 0 0", line_w[0], vazio_w[0], est_w[0], pronto_w[0]); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        lows = 0; prs = 0;
        repeat (40) begin
            @(negedge clk);
            if (line_w[0] !== 1'b1) lows++;
            if (pronto_w[0] !== 1'b0) prs++;
        end
        n_checks++; if (lows !== 0 || prs !== 0)
            $display("FAIL rstmid_flushed: lows %0d pronto %0d expected 0 0", lows, prs); else n_pass++;
        w_b = 8'($urandom_range(0, 255));
        nb = modelo(0, w_b, exp, pb);
        @(negedge clk); dados[0] = w_b; partida[0] = 1'b1;
        fork
            begin @(negedge clk); partida[0] = 1'b0; end
            capture(0, nb, found, gap, wf, pr_in, ticks, pr_end, line_end);
        join
        n_checks++;
        if (!found) $display("FAIL rstmid_timeout: no start bit after reset");
        else if (wf !== exp) $display("FAIL rstmid_wave: got %h expected %h", wf, exp);
        else n_pass++;
        n_checks++; if (gap !== 2 || pr_in !== 0 || pr_end !== 1'b1)
            $display("FAIL rstmid_end: gap %0d pronto in %0d end %b expected 2 0 1", gap, pr_in, pr_end); else n_pass++;
        $display("reset mid-frame byte=%h then byte=%h pronto=%b", x, w_b, pr_end);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_frames();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
